load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the single-cycle control decoder.
- Consumes data_mem_read_enable / data_mem_write_enable, the ALU-computed address and rs2 data, and runs a valid/ready transaction on the data bus.
- Stalls the core by gating PC and regfile writes until the access completes.
- Returns aligned, sign/zero-extended load data to the writeback mux (select 3'b001).

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT_RSP before bus_error; 0 disables the timeout.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-low reset
- data_mem_read_enable  in  1  load in current instruction (from control)
- data_mem_write_enable  in  1  store in current instruction (from control)
- inst_funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU; SB/SH/SW)
- address  in  32  byte address (ALU result)
- store_data  in  32  rs2 value
- load_data  out  32  extended load result
- stall  out  1  high = core must hold PC and suppress regfile write
- misaligned_fault  out  1  one-cycle pulse on misaligned access
- bus_error  out  1  one-cycle pulse on timeout
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_write  out  1  1 = write
- bus_addr  out  32  word address, {address[31:2],2'b00}
- bus_byte_enable  out  4  lane mask
- bus_wdata  out  32  store data replicated to lanes
- bus_rsp_valid  in  1  read data valid
- bus_rdata  in  32  read data (word)

Behaviour:
- States: IDLE, REQ, WAIT_RSP, DONE.
- Reset (reset==0 at a clock edge): state=IDLE; timeout counter=0; captured address/funct3/rdata regs=0.
- Reset outputs: all bus outputs 0, stall=0, load_data=0, faults=0.
- Reset mid-transaction drops the request immediately; a late bus_rsp_valid is ignored.
- Access = read_enable | write_enable. Both asserted is treated as a read.
- IDLE, access, aligned: capture address/funct3/store_data; go to REQ; stall=1 combinationally in that same cycle.
- IDLE, access, misaligned (halfword with addr[0]=1; word with addr[1:0]!=0):
  - no bus request; misaligned_fault=1 for this cycle; stall=0; state stays IDLE.
  - The instruction retires with regfile write suppressed. This unit outputs suppress = misaligned_fault, which the core ORs into write gating.
- REQ: bus_req_valid=1; addr, byte_enable, wdata and write are held stable until ready.
  - On bus_req_ready: a write goes to DONE; a read goes to WAIT_RSP.
- WAIT_RSP: on bus_rsp_valid, capture bus_rdata and go to DONE. bus_rsp_valid in any other state is ignored.
- DONE: stall=0 for exactly one cycle, so the instruction commits. load_data is valid this cycle. Next state is IDLE.
- stall=1 in REQ and WAIT_RSP, and in IDLE when an aligned access is detected.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- bus_wdata: byte replicated x4; half replicated x2; word as-is.
- Load formatting uses captured rdata shifted right by 8*addr[1:0]:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
  - Undefined funct3 (3'b011, 3'b110, 3'b111) behaves as LW/SW.
- load_data is combinational from captured regs; it holds its value outside DONE.
- Timeout: counter increments each cycle in REQ/WAIT_RSP and clears elsewhere.
  - When counter==TIMEOUT_CYCLES-1 and the transaction is not completing: bus_error=1, bus_req_valid drops, go to DONE.
  - load_data=0 in that case.
  - Completion in the same cycle as the timeout hit takes priority (no error).
- Back-to-back accesses: a new access is seen in IDLE the cycle after DONE; there is no bubble beyond DONE.
- Zero-wait bus (ready in the first REQ cycle, rsp in the next): load latency 3 cycles (IDLE-detect, REQ, WAIT_RSP), plus DONE commit. Store latency 2 cycles plus DONE.

Decomposition:
- Shared package (config.sv constants): FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW, lsu_state_t enum, BYTE_ENABLE helper constants.
- Sub-module load_data_formatter: combinational; inputs rdata, addr[1:0], funct3; output extended word. Also used by the multicycle core.

Test Plan:
- LW, addr 0x100, ready=1 immediately, rsp next cycle with rdata=0xDEADBEEF -> byte_enable=4'b1111; stall high 3 cycles; DONE load_data=0xDEADBEEF.
- LB addr 0x103, rdata=0x80AABBCC -> byte_enable=4'b1000; load_data=0xFFFFFF80. LBU, same data -> 0x00000080.
- SH addr 0x102, store_data=0x1234ABCD, ready delayed 4 cycles -> byte_enable=4'b1100; wdata=0xABCDABCD; fields stable for all 4 cycles; no WAIT_RSP.
- LW addr 0x101 -> misaligned_fault 1 cycle; no bus_req_valid; stall=0. SH addr 0x203 -> same.
- TIMEOUT_CYCLES=4, read, ready never asserted -> bus_error on 4th REQ cycle; DONE with load_data=0; back to IDLE.
- Reset low during WAIT_RSP, rsp arrives the cycle after -> IDLE, outputs 0, response ignored; the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and lane helpers for the load/store unit and its load-data formatter.
package load_store_unit_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_t;

  // Undefined encodings (011, 110, 111) fall through to word accesses.
  function automatic access_size_t access_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input access_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return BE_BYTE << off;
      SZ_HALF: return BE_HALF << {off[1], 1'b0};
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input access_size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_data_formatter.sv
// Aligns a bus word to the accessed byte lane and sign/zero-extends it by funct3.
module load_data_formatter
  import load_store_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_load_data = w_shifted;
    case (i_funct3)
      FUNCT3_LB:  o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      FUNCT3_LH:  o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      FUNCT3_LBU: o_load_data = {24'd0, w_shifted[7:0]};
      FUNCT3_LHU: o_load_data = {16'd0, w_shifted[15:0]};
      default:    o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one valid/ready bus transaction per load/store and stalls the core meanwhile.
//   state       | meaning
//   ST_IDLE     | waiting for an access; misaligned accesses fault here without a bus request
//   ST_REQ      | request presented, fields held until i_bus_req_ready
//   ST_WAIT_RSP | read accepted, waiting for i_bus_rsp_valid
//   ST_DONE     | one-cycle commit slot, stall released, load data valid
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_data_mem_read_enable,
  input  logic        i_data_mem_write_enable,
  input  logic [2:0]  i_inst_funct3,
  input  logic [31:0] i_address,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic        o_stall,
  output logic        o_misaligned_fault,
  output logic        o_bus_error,
  output logic        o_bus_req_valid,
  input  logic        i_bus_req_ready,
  output logic        o_bus_req_write,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_byte_enable,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rsp_valid,
  input  logic [31:0] i_bus_rdata
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state;
  logic [31:0] r_timeout_cnt;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic [31:0] r_rdata;
  logic [1:0]  r_ld_addr_lo;
  logic [2:0]  r_ld_funct3;
  logic        r_bus_req_valid;
  logic        r_bus_req_write;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_byte_enable;
  logic [31:0] r_bus_wdata;

  access_size_t w_size;
  logic w_access, w_is_write, w_misaligned, w_accept, w_busy;
  logic w_completing, w_timeout_hit;

  assign w_access     = i_data_mem_read_enable | i_data_mem_write_enable;
  assign w_is_write   = i_data_mem_write_enable & ~i_data_mem_read_enable;
  assign w_size       = access_size(i_inst_funct3[1:0]);
  assign w_misaligned = ((w_size == SZ_HALF) && i_address[0]) ||
                        ((w_size == SZ_WORD) && (i_address[1:0] != 2'b00));
  assign w_accept     = (r_state == ST_IDLE) && w_access && !w_misaligned;
  assign w_busy       = (r_state == ST_REQ) || (r_state == ST_WAIT_RSP);

  // An accepted read is not complete yet; only a write handshake or a read response finishes.
  assign w_completing  = ((r_state == ST_REQ) && i_bus_req_ready && r_bus_req_write) ||
                         ((r_state == ST_WAIT_RSP) && i_bus_rsp_valid);
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && w_busy && (r_timeout_cnt == TIMEOUT_LAST);

  assign o_stall            = w_accept || w_busy;
  assign o_misaligned_fault = (r_state == ST_IDLE) && w_access && w_misaligned;
  assign o_bus_error        = w_timeout_hit && !w_completing;
  assign o_bus_req_valid    = r_bus_req_valid;
  assign o_bus_req_write    = r_bus_req_write;
  assign o_bus_addr         = r_bus_addr;
  assign o_bus_byte_enable  = r_bus_byte_enable;
  assign o_bus_wdata        = r_bus_wdata;

  load_data_formatter u_formatter (
    .i_rdata    (r_rdata),
    .i_addr_lo  (r_ld_addr_lo),
    .i_funct3   (r_ld_funct3),
    .o_load_data(o_load_data)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state           <= ST_IDLE;
      r_timeout_cnt     <= '0;
      r_addr_lo         <= '0;
      r_funct3          <= '0;
      r_rdata           <= '0;
      r_ld_addr_lo      <= '0;
      r_ld_funct3       <= '0;
      r_bus_req_valid   <= 1'b0;
      r_bus_req_write   <= 1'b0;
      r_bus_addr        <= '0;
      r_bus_byte_enable <= '0;
      r_bus_wdata       <= '0;
    end else begin
      if (w_busy) r_timeout_cnt <= r_timeout_cnt + 32'd1;
      else        r_timeout_cnt <= '0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr_lo         <= i_address[1:0];
            r_funct3          <= i_inst_funct3;
            r_bus_req_valid   <= 1'b1;
            r_bus_req_write   <= w_is_write;
            r_bus_addr        <= {i_address[31:2], 2'b00};
            r_bus_byte_enable <= byte_enable(w_size, i_address[1:0]);
            r_bus_wdata       <= lane_replicate(w_size, i_store_data);
            r_state           <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (o_bus_error) begin
            r_bus_req_valid <= 1'b0;
            r_rdata         <= '0;
            r_state         <= ST_DONE;
          end else if (i_bus_req_ready) begin
            r_bus_req_valid <= 1'b0;
            r_state         <= r_bus_req_write ? ST_DONE : ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (i_bus_rsp_valid) begin
            r_rdata      <= i_bus_rdata;
            r_ld_addr_lo <= r_addr_lo;
            r_ld_funct3  <= r_funct3;
            r_state      <= ST_DONE;
          end else if (o_bus_error) begin
            r_rdata <= '0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a cycle-counting reference model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_data_mem_read_enable = 1'b0;
  logic        i_data_mem_write_enable = 1'b0;
  logic [2:0]  i_inst_funct3 = '0;
  logic [31:0] i_address = '0;
  logic [31:0] i_store_data = '0;
  logic [31:0] o_load_data;
  logic        o_stall;
  logic        o_misaligned_fault;
  logic        o_bus_error;
  logic        o_bus_req_valid;
  logic        i_bus_req_ready = 1'b0;
  logic        o_bus_req_write;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_byte_enable;
  logic [31:0] o_bus_wdata;
  logic        i_bus_rsp_valid = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_load = '0;
  logic [2:0] store_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock                (i_clock),
    .i_reset                (i_reset),
    .i_data_mem_read_enable (i_data_mem_read_enable),
    .i_data_mem_write_enable(i_data_mem_write_enable),
    .i_inst_funct3          (i_inst_funct3),
    .i_address              (i_address),
    .i_store_data           (i_store_data),
    .o_load_data            (o_load_data),
    .o_stall                (o_stall),
    .o_misaligned_fault     (o_misaligned_fault),
    .o_bus_error            (o_bus_error),
    .o_bus_req_valid        (o_bus_req_valid),
    .i_bus_req_ready        (i_bus_req_ready),
    .o_bus_req_write        (o_bus_req_write),
    .o_bus_addr             (o_bus_addr),
    .o_bus_byte_enable      (o_bus_byte_enable),
    .o_bus_wdata            (o_bus_wdata),
    .i_bus_rsp_valid        (i_bus_rsp_valid),
    .i_bus_rdata            (i_bus_rdata)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] s, b, h;
    s = w >> (8 * off);
    b = s & 32'hFF;
    h = s & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return s;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, o_stall, 0);
    check({tag, "_valid"}, o_bus_req_valid, 0);
    check({tag, "_write"}, o_bus_req_write, 0);
    check({tag, "_addr"}, o_bus_addr, 0);
    check({tag, "_be"}, o_bus_byte_enable, 0);
    check({tag, "_wdata"}, o_bus_wdata, 0);
    check({tag, "_load"}, o_load_data, 0);
    check({tag, "_fault"}, o_misaligned_fault, 0);
    check({tag, "_berr"}, o_bus_error, 0);
  endtask

  // Entered and left just after a rising edge with the DUT in IDLE.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int req_dly, input int rsp_dly);
    bit is_wr, mis, in_req, fin, err, completing;
    int size, off, c, k;
    logic [31:0] exp_be, exp_wd;
    is_wr  = wr && !rd;
    size   = ref_size(f3);
    off    = int'(addr[1:0]);
    mis    = (off % size) != 0;
    exp_be = (size == 4) ? 32'hF : (((size == 2) ? 32'h3 : 32'h1) << off);
    exp_wd = (size == 1) ? (sdata & 32'hFF) * 32'h01010101 :
             (size == 2) ? (sdata & 32'hFFFF) * 32'h00010001 : sdata;

    i_data_mem_read_enable  = rd;
    i_data_mem_write_enable = wr;
    i_inst_funct3           = f3;
    i_address               = addr;
    i_store_data            = sdata;
    i_bus_req_ready         = 1'b0;
    i_bus_rsp_valid         = 1'b0;
    @(negedge i_clock);
    check("idle_load_hold", o_load_data, exp_load);
    check("idle_fault", o_misaligned_fault, mis);
    check("idle_stall", o_stall, !mis);
    check("idle_valid", o_bus_req_valid, 0);
    check("idle_berr", o_bus_error, 0);
    @(posedge i_clock); #1;
    i_data_mem_read_enable  = 1'b0;
    i_data_mem_write_enable = 1'b0;
    i_inst_funct3           = 3'($urandom);
    i_address               = $urandom;
    i_store_data            = $urandom;
    if (mis) return;

    c = 0; k = 0; in_req = 1'b1; fin = 1'b0; err = 1'b0;
    while (!fin) begin
      if (in_req) begin
        i_bus_req_ready = (k == req_dly);
        i_bus_rsp_valid = 1'($urandom);
        i_bus_rdata     = $urandom;
      end else begin
        i_bus_req_ready = 1'($urandom);
        i_bus_rsp_valid = (k == rsp_dly);
        i_bus_rdata     = (k == rsp_dly) ? rdata : $urandom;
      end
      completing = in_req ? (i_bus_req_ready && is_wr) : i_bus_rsp_valid;
      err = (c == TO - 1) && !completing;
      @(negedge i_clock);
      check("busy_valid", o_bus_req_valid, in_req);
      check("busy_stall", o_stall, 1);
      check("busy_berr", o_bus_error, err);
      check("busy_fault", o_misaligned_fault, 0);
      if (in_req) begin
        check("req_write", o_bus_req_write, is_wr);
        check("req_addr", o_bus_addr, addr & ~32'h3);
        check("req_be", o_bus_byte_enable, exp_be);
        if (is_wr) check("req_wdata", o_bus_wdata, exp_wd);
      end
      @(posedge i_clock); #1;
      if (err) fin = 1'b1;
      else if (in_req && i_bus_req_ready) begin
        if (is_wr) fin = 1'b1;
        else begin
          in_req = 1'b0;
          k = -1;
        end
      end else if (!in_req && i_bus_rsp_valid) fin = 1'b1;
      k++;
      c++;
    end

    i_bus_req_ready = 1'b0;
    i_bus_rsp_valid = 1'b0;
    if (!is_wr) exp_load = err ? 32'h0 : ref_load(f3, off, rdata);
    @(negedge i_clock);
    check("done_stall", o_stall, 0);
    check("done_valid", o_bus_req_valid, 0);
    check("done_berr", o_bus_error, 0);
    check("done_load", o_load_data, exp_load);
    @(posedge i_clock); #1;
  endtask

  initial begin
    bit rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int sel, sz;

    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    check_reset_outputs("reset");
    @(posedge i_clock); #1;
    i_reset = 1'b1;

    do_access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    check("lw_plan", o_load_data, 32'hDEADBEEF);
    do_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80AABBCC, 0, 1);
    check("lb_plan", o_load_data, 32'hFFFFFF80);
    do_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80AABBCC, 2, 0);
    check("lbu_plan", o_load_data, 32'h00000080);
    do_access(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 3, 0);
    check("sh_hold_load", o_load_data, 32'h00000080);
    do_access(1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0);
    do_access(0, 1, 3'd1, 32'h203, 32'h5A5A5A5A, 32'h0, 0, 0);
    do_access(1, 0, 3'd2, 32'h400, 32'h0, 32'hCAFEF00D, 100, 0);
    check("timeout_load", o_load_data, 32'h0);

    // Reset lands while waiting for a read response; the late response must be dropped.
    i_data_mem_read_enable = 1'b1;
    i_inst_funct3 = 3'd2;
    i_address = 32'h300;
    @(negedge i_clock);
    check("rst_idle_stall", o_stall, 1);
    @(posedge i_clock); #1;
    i_data_mem_read_enable = 1'b0;
    i_bus_req_ready = 1'b1;
    @(negedge i_clock);
    check("rst_req_valid", o_bus_req_valid, 1);
    @(posedge i_clock); #1;
    i_bus_req_ready = 1'b0;
    i_reset = 1'b0;
    @(negedge i_clock);
    check("rst_wait_stall", o_stall, 1);
    @(posedge i_clock); #1;
    i_reset = 1'b1;
    i_bus_rsp_valid = 1'b1;
    i_bus_rdata = 32'h5555AAAA;
    @(negedge i_clock);
    check_reset_outputs("midrst");
    @(posedge i_clock); #1;
    i_bus_rsp_valid = 1'b0;
    @(negedge i_clock);
    check("late_rsp_load", o_load_data, 32'h0);
    check("late_rsp_stall", o_stall, 0);
    @(posedge i_clock); #1;
    exp_load = 32'h0;
    do_access(1, 0, 3'd2, 32'h304, 32'h0, 32'h13579BDF, 0, 0);
    check("post_rst_lw", o_load_data, 32'h13579BDF);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      rd = (sel < 5) || (sel == 9);
      wr = (sel >= 5);
      f3 = rd ? 3'($urandom) : store_f3[$urandom_range(0, 5)];
      a = $urandom;
      sz = ref_size(f3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2) a[0] = 1'b0;
        if (sz == 4) a[1:0] = 2'b00;
      end
      do_access(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
